uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit path. Accepts one parallel byte per valid/ready handshake and serialises it LSB-first onto TX_OUT. Each frame is a start bit, DATA_WIDTH data bits, an optional even/odd parity bit, and one or two stop bits. Bit timing comes from an internal prescale counter driven by the system clock. Pairs with the receive-side deserialiser on the same serial line format.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 16, width of the PRESCALE port

Ports:
CLK  input  1  system clock; all logic on its rising edge
RST  input  1  reset, synchronous, active-high
P_DATA  input  DATA_WIDTH  byte to transmit; sampled on acceptance only
DATA_VALID  input  1  P_DATA valid request
READY  output  1  block can accept; a transfer occurs on a CLK edge where DATA_VALID && READY
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits, 0 = one
PRESCALE  input  PRESCALE_W  CLK cycles per serial bit; 0 treated as 1
TX_OUT  output  1  serial line, idles high
BUSY  output  1  frame in progress (state != IDLE)
TX_DONE  output  1  one-cycle pulse after the final stop bit completes

Behaviour:
- Reset (RST=1 at an edge): state IDLE, TX_OUT=1, BUSY=0, TX_DONE=0, READY=1. All counters and shift register cleared. Reset mid-frame aborts the frame; TX_OUT is 1 from the next cycle and nothing resumes.
- Acceptance latches P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE (0→1) into internal registers. Input changes during a frame have no effect.
- Parity is computed once from the latched data. Even: bit = XOR of data. Odd: bit = ~XOR.
- DATA_VALID while READY=0 is ignored. There is no queue; the source must hold the request.
- States and transitions:
  - IDLE: TX_OUT=1. On acceptance → START.
  - START: TX_OUT=0 for P cycles → DATA.
  - DATA: TX_OUT = shift[0], LSB first. Each bit lasts P cycles; bit counter runs 0..DATA_WIDTH-1. After the last bit → PARITY if PAR_EN, else STOP.
  - PARITY: TX_OUT = parity bit for P cycles → STOP.
  - STOP: TX_OUT=1 for P cycles (1 stop bit) or 2P cycles (STOP2=1). Then → IDLE, or → START if accepted in this cycle.
- All outputs are registered. Acceptance at edge k puts the start bit on TX_OUT from cycle k+1.
- Frame length is (2 + DATA_WIDTH + PAR_EN + STOP2) × P cycles exactly.
- READY = (state==IDLE) || (state==STOP && final cycle of final stop bit). This allows zero-gap back-to-back frames.
- TX_DONE is high for exactly one cycle: the cycle following the final stop-bit cycle. This holds even when the next frame's start bit begins in that same cycle.
- BUSY is 1 from cycle k+1 through the final stop cycle. It stays 1 continuously across back-to-back frames.
- Prescale counter counts 0..P-1 inside each bit; the bit advances on P-1. With P=1 every bit lasts one cycle.
- Bit counter and prescale counter reset at every bit and state boundary; there is no wrap into undefined states. Unused state encodings → IDLE.
- Simultaneous RST and DATA_VALID: reset wins and nothing is accepted.

Test Plan:
1. PRESCALE=4, PAR_EN=0, STOP2=0; send 0xA5, accepted at edge 0 → TX_OUT over cycles 1–40 in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1. READY=1 in cycle 40. TX_DONE=1 in cycle 41 only. BUSY=1 in cycles 1–40.
2. PRESCALE=2, PAR_EN=1. Send 0x07 with PAR_TYP=0 → parity bit 1. Send with PAR_TYP=1 → parity bit 0. Frame is 11 bits = 22 cycles.
3. Back-to-back: DATA_VALID held high with 0x55 then 0x0F, PRESCALE=3 → the second start bit begins in the cycle immediately after the first stop bit, with no idle-high gap. TX_DONE pulses once per frame. BUSY never drops.
4. STOP2=1, PRESCALE=0 (treated as 1), send 0xFF → 11 cycles: 0, eight 1s, 1, 1. TX_DONE at cycle 12. Changing P_DATA and PRESCALE mid-frame has no effect.
5. Reset mid-frame: assert RST during data bit 3 of 0x00 → TX_OUT=1, READY=1, BUSY=0 and TX_DONE=0 the next cycle. A new request after release produces a full clean frame.
6. DATA_VALID pulsed for 1 cycle while BUSY and not in the final stop cycle → ignored; no second frame is sent.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: start, LSB-first data, optional parity, 1/2 stop.
// Bit timing from a per-frame latched prescale; zero-gap back-to-back frames.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] r_p;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_stop_idx;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ready;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_fin;
  logic [PRESCALE_W-1:0] w_cnt_inc;
  logic [PRESCALE_W-1:0] w_p_in;

  assign w_accept  = DATA_VALID && r_ready;
  assign w_last    = (r_cnt == r_p - ONE);
  assign w_fin     = (r_stop_idx == r_stop2);
  assign w_cnt_inc = r_cnt + ONE;
  assign w_p_in    = (PRESCALE == '0) ? ONE : PRESCALE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_p        <= ONE;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      // accept only happens in IDLE or the final stop cycle
      if (w_accept) begin
        r_shift  <= P_DATA;
        r_par    <= (^P_DATA) ^ PAR_TYP;
        r_par_en <= PAR_EN;
        r_stop2  <= STOP2;
        r_p      <= w_p_in;
      end
      case (r_state)
        IDLE: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          if (w_accept) begin
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (w_last) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_bit == LAST_BIT) begin
              r_bit <= '0;
              if (r_par_en) begin
                r_state <= PARITY;
                r_tx    <= r_par;
              end else begin
                r_state    <= STOP;
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
                r_ready    <= (r_p == ONE) && !r_stop2;
              end
            end else begin
              r_bit   <= r_bit + BW'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PARITY: begin
          if (w_last) begin
            r_state    <= STOP;
            r_tx       <= 1'b1;
            r_cnt      <= '0;
            r_stop_idx <= 1'b0;
            r_ready    <= (r_p == ONE) && !r_stop2;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        STOP: begin
          if (w_last && w_fin) begin
            r_done     <= 1'b1;
            r_cnt      <= '0;
            r_stop_idx <= 1'b0;
            if (w_accept) begin
              r_state <= START;
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end
          end else if (w_last) begin
            r_stop_idx <= 1'b1;
            r_cnt      <= '0;
            r_ready    <= (r_p == ONE);
          end else begin
            r_cnt   <= w_cnt_inc;
            r_ready <= (w_cnt_inc == r_p - ONE) && w_fin;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_bit      <= '0;
          r_stop_idx <= 1'b0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_ready    <= 1'b1;
        end
      endcase
    end
  end

  assign READY   = r_ready;
  assign TX_OUT  = r_tx;
  assign BUSY    = r_busy;
  assign TX_DONE = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: directed frames plus random frames
// compared cycle by cycle against a bit-list frame model.
module tb_uart_tx_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  P_DATA = '0;
  logic        DATA_VALID = 1'b0;
  logic        PAR_EN = 1'b0;
  logic        PAR_TYP = 1'b0;
  logic        STOP2 = 1'b0;
  logic [15:0] PRESCALE = 16'd1;
  logic        READY;
  logic        TX_OUT;
  logic        BUSY;
  logic        TX_DONE;

  int n_checks = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .READY(READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .BUSY(BUSY), .TX_DONE(TX_DONE)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level, one entry per clock cycle of the frame
  task automatic build(input logic [7:0] d, input bit pe, input bit pt,
                       input bit s2, input int pr);
    bit bits[$];
    int p;
    p = (pr == 0) ? 1 : pr;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[j])
      for (int c = 0; c < p; c++) exp_q.push_back(bits[j]);
  endtask

  task automatic start_req(input logic [7:0] d, input bit pe, input bit pt,
                           input bit s2, input int pr);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    STOP2 = s2;
    PRESCALE = 16'(pr);
    DATA_VALID = 1'b1;
    chk("req_ready", READY, 1);
    step();
  endtask

  task automatic check_frame(input logic [7:0] d, input bit pe, input bit pt,
                             input bit s2, input int pr, input bit prev_done,
                             input bit hold, input logic [7:0] nd,
                             input int pulse);
    int len;
    build(d, pe, pt, s2, pr);
    len = exp_q.size();
    if (hold) begin
      P_DATA = nd;
    end else begin
      DATA_VALID = 1'b0;
      P_DATA = 8'($urandom);
      PRESCALE = 16'($urandom_range(0, 7));
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      STOP2 = 1'($urandom);
    end
    for (int i = 0; i < len; i++) begin
      if (!hold) DATA_VALID = (i == pulse);
      chk("tx", TX_OUT, exp_q[i]);
      chk("busy", BUSY, 1);
      chk("ready", READY, (i == len - 1) ? 1 : 0);
      chk("done", TX_DONE, (i == 0 && prev_done) ? 1 : 0);
      step();
    end
    if (!hold) DATA_VALID = 1'b0;
  endtask

  task automatic after_idle();
    chk("end_done", TX_DONE, 1);
    chk("end_busy", BUSY, 0);
    chk("end_tx", TX_OUT, 1);
    chk("end_ready", READY, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_done", TX_DONE, 0);
      chk("idle_tx", TX_OUT, 1);
      chk("idle_busy", BUSY, 0);
    end
  endtask

  initial begin
    logic [7:0] cd, nd;
    bit cpe, cpt, cs2, chain_in, chain_out;
    int cpr, p, len, pulse;

    RST = 1'b1;
    step();
    step();
    chk("rst_tx", TX_OUT, 1);
    chk("rst_ready", READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", TX_DONE, 0);
    RST = 1'b0;
    step();

    start_req(8'hA5, 0, 0, 0, 4);
    check_frame(8'hA5, 0, 0, 0, 4, 0, 0, 8'h00, -1);
    after_idle();

    start_req(8'h07, 1, 0, 0, 2);
    check_frame(8'h07, 1, 0, 0, 2, 0, 0, 8'h00, -1);
    after_idle();
    start_req(8'h07, 1, 1, 0, 2);
    check_frame(8'h07, 1, 1, 0, 2, 0, 0, 8'h00, -1);
    after_idle();

    start_req(8'h55, 0, 0, 0, 3);
    check_frame(8'h55, 0, 0, 0, 3, 0, 1, 8'h0F, -1);
    check_frame(8'h0F, 0, 0, 0, 3, 1, 0, 8'h00, -1);
    after_idle();

    start_req(8'hFF, 0, 0, 1, 0);
    check_frame(8'hFF, 0, 0, 1, 0, 0, 0, 8'h00, -1);
    after_idle();

    start_req(8'h00, 0, 0, 0, 4);
    DATA_VALID = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("pre_rst_tx", TX_OUT, 0);
      step();
    end
    RST = 1'b1;
    step();
    chk("mid_rst_tx", TX_OUT, 1);
    chk("mid_rst_ready", READY, 1);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", TX_DONE, 0);
    DATA_VALID = 1'b1;
    step();
    chk("rst_vs_valid_busy", BUSY, 0);
    chk("rst_vs_valid_tx", TX_OUT, 1);
    RST = 1'b0;
    DATA_VALID = 1'b0;
    step();
    chk("post_rst_tx", TX_OUT, 1);
    chk("post_rst_busy", BUSY, 0);
    start_req(8'h96, 1, 0, 0, 3);
    check_frame(8'h96, 1, 0, 0, 3, 0, 0, 8'h00, -1);
    after_idle();

    start_req(8'h3C, 1, 1, 0, 2);
    check_frame(8'h3C, 1, 1, 0, 2, 0, 0, 8'h00, 5);
    after_idle();

    chain_in = 1'b0;
    cd = 8'($urandom);
    cpe = 1'($urandom);
    cpt = 1'($urandom);
    cs2 = 1'($urandom);
    cpr = $urandom_range(0, 6);
    for (int k = 0; k < 25; k++) begin
      if (!chain_in) begin
        cd = 8'($urandom);
        cpe = 1'($urandom);
        cpt = 1'($urandom);
        cs2 = 1'($urandom);
        cpr = $urandom_range(0, 6);
        start_req(cd, cpe, cpt, cs2, cpr);
      end
      chain_out = (k < 24) && ($urandom_range(0, 2) == 0);
      nd = 8'($urandom);
      p = (cpr == 0) ? 1 : cpr;
      len = (2 + 8 + int'(cpe) + int'(cs2)) * p;
      pulse = -1;
      if (!chain_out && $urandom_range(0, 1) == 1)
        pulse = $urandom_range(0, len - 2);
      check_frame(cd, cpe, cpt, cs2, cpr, chain_in, chain_out, nd, pulse);
      if (!chain_out) after_idle();
      chain_in = chain_out;
      cd = nd;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
